// File: rtl/axi_fifo_reg_core.sv
// axi_fifo_reg_core: register-mapped TX/RX FIFO pair behind the AXI4-Lite
// register interface. CPU writes feed an AXI-Stream master through the TX FIFO;
// an AXI-Stream slave fills the RX FIFO, which the CPU drains by reading.
module axi_fifo_reg_core #(
  parameter int DEPTH = 16
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic [31:0] addr,
  input  logic        addr_vld,
  input  logic [31:0] data_out,
  input  logic        data_out_vld,
  input  logic        data_out_strb,
  output logic [31:0] data_in,
  output logic        data_in_vld,
  input  logic        data_in_ack,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Full when the wrap bits differ and the index bits match.
  function automatic logic fifo_full(input logic [PW-1:0] wr, input logic [PW-1:0] rd);
    return (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  endfunction

  logic [31:0]   tx_mem [DEPTH];
  logic [31:0]   rx_mem [DEPTH];
  logic [PW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [PW-1:0] tx_cnt, rx_cnt;
  logic [7:0]    tx_level, rx_level;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_ovf, rx_udf, pend_pop, run;

  logic [9:0]    a10;
  logic          wr_en, rd_en;
  logic          tx_wr_hit, tx_push, tx_pop, tx_ovf_set;
  logic          ctrl_wr, tx_flush, rx_flush, flag_clr;
  logic          rx_rd_hit, rx_rd_ok, rx_udf_set, rx_push, rx_pop;
  logic [31:0]   rx_head, status;

  // Upper address bits are outside the decoded window.
  logic          unused_addr;
  assign unused_addr = &{1'b0, addr[31:10]};

  assign a10      = addr[9:0];
  assign wr_en    = addr_vld & data_out_vld & data_out_strb;
  assign rd_en    = addr_vld & ~data_out_vld;

  assign tx_cnt   = tx_wr_ptr - tx_rd_ptr;
  assign rx_cnt   = rx_wr_ptr - rx_rd_ptr;
  assign tx_level = 8'(tx_cnt);
  assign rx_level = 8'(rx_cnt);
  assign tx_full  = fifo_full(tx_wr_ptr, tx_rd_ptr);
  assign rx_full  = fifo_full(rx_wr_ptr, rx_rd_ptr);
  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);

  assign ctrl_wr  = wr_en & (a10 == 10'd3);
  assign tx_flush = ctrl_wr & data_out[0];
  assign rx_flush = ctrl_wr & data_out[1];
  assign flag_clr = ctrl_wr & data_out[2];

  // Full check uses pre-pop state: a same-cycle stream pop does not make room.
  assign tx_wr_hit  = wr_en & (a10 == 10'd0);
  assign tx_push    = tx_wr_hit & ~tx_full;
  assign tx_ovf_set = tx_wr_hit & tx_full;
  assign tx_pop     = m_axis_tvalid & m_axis_tready;

  assign m_axis_tvalid = ~tx_empty;
  assign m_axis_tdata  = tx_empty ? 32'd0 : tx_mem[tx_rd_ptr[AW-1:0]];

  assign s_axis_tready = run & ~rx_full;
  assign rx_push       = s_axis_tvalid & s_axis_tready;

  // A read only marks the head for popping; the pop lands on the response ack.
  assign rx_rd_hit  = rd_en & (a10 == 10'd1);
  assign rx_rd_ok   = rx_rd_hit & ~rx_empty;
  assign rx_udf_set = rx_rd_hit & rx_empty;
  assign rx_pop     = pend_pop & data_in_ack;

  assign rx_head = rx_empty ? 32'd0 : rx_mem[rx_rd_ptr[AW-1:0]];
  assign status  = {8'd0, rx_level, tx_level, 2'b00, rx_udf, tx_ovf,
                    rx_empty, rx_full, tx_empty, tx_full};

  assign data_in_vld = S_AXI_ARESETN;

  // Zero-latency read mux; forced to zero while reset is held.
  always_comb begin
    data_in = 32'd0;
    if (S_AXI_ARESETN) begin
      case (a10)
        10'd1:   data_in = rx_head;
        10'd2:   data_in = status;
        default: data_in = 32'd0;
      endcase
    end
  end

  // FIFO storage: data only, never reset; writes suppressed on a flush cycle.
  always_ff @(posedge S_AXI_ACLK) begin
    if (tx_push && !tx_flush) tx_mem[tx_wr_ptr[AW-1:0]] <= data_out;
    if (rx_push && !rx_flush) rx_mem[rx_wr_ptr[AW-1:0]] <= s_axis_tdata;
  end

  // Control state: pointers, sticky flags, pending pop and the run enable.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      tx_ovf    <= 1'b0;
      rx_udf    <= 1'b0;
      pend_pop  <= 1'b0;
      run       <= 1'b0;
    end else begin
      run <= 1'b1;
      if (tx_flush) begin
        tx_rd_ptr <= tx_wr_ptr;
      end else begin
        if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
        if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      end
      if (rx_flush) begin
        rx_rd_ptr <= rx_wr_ptr;
        pend_pop  <= 1'b0;
      end else begin
        if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
        if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
        pend_pop <= (pend_pop & ~rx_pop) | rx_rd_ok;
      end
      // Set wins over a same-cycle clear.
      tx_ovf <= (tx_ovf & ~flag_clr) | tx_ovf_set;
      rx_udf <= (rx_udf & ~flag_clr) | rx_udf_set;
    end
  end

endmodule
